multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning consecutive mem_ready-low cycles in one memory state before bus_error.
REQ-002 SHALL have ports (one per line):
  clk  in  1  rising-edge clock, the only clock
  reset  in  1  synchronous, active-low reset
  opcode  in  6  instruction[31:26] from instruction register
  mem_ready  in  1  memory completes the current access this cycle
  pc_write, pc_write_cond_eq, pc_write_cond_ne  out  1 each  PC update enables
  i_or_d, mem_read, mem_write, ir_write  out  1 each  memory/IR controls
  reg_dst, mem_to_reg, reg_write, zero_ext  out  1 each  register-file/immediate controls
  alu_src_a  out  1  0=PC, 1=reg A
  alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
  pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
  alu_op  out  3  ALUOp to the ALU control stage
  state  out  4  current state code
  illegal, bus_error  out  1 each  one-cycle fault pulses

Function
REQ-003 SHALL be a Moore FSM; all outputs decode from state, plus mem_ready for pc_write/ir_write/mem_write completion qualifiers.
REQ-004 States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11; codes 12-15 SHALL transition to FETCH.
REQ-005 alu_op encodings: R-type 111, ADDI 110, ORI 101, ANDI 011, LUI 001, address/PC add 010, branch compare 100.
REQ-006 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00; ir_write=pc_write=1 only when mem_ready=1; advance to DECODE on mem_ready=1, else stay.
REQ-007 DECODE: alu_src_a=0, alu_src_b=11, alu_op=010; next state by opcode: 000000->R_EXEC; 100011/101011->MEM_ADDR; 001000/001101/001100/001111->I_EXEC; 000100/000101->BRANCH; 000010->JUMP; any other->FETCH with illegal=1 for that cycle.
REQ-008 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111 -> R_WB; R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, alu_op=111 -> FETCH.
REQ-009 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op per opcode (REQ-005), zero_ext=1 for ORI/ANDI -> I_WB; I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, same alu_op/zero_ext -> FETCH.
REQ-010 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010; ->MEM_READ if LW, MEM_WRITE if SW.
REQ-011 MEM_READ: mem_read=1, i_or_d=1; ->MEM_WB on mem_ready=1 else stay; MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
REQ-012 MEM_WRITE: i_or_d=1, mem_write=1 held until mem_ready=1; -> FETCH on mem_ready=1.
REQ-013 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_source=01, pc_write_cond_eq=1 for BEQ, pc_write_cond_ne=1 for BNE -> FETCH.
REQ-014 JUMP: pc_source=10, pc_write=1 -> FETCH.
REQ-015 Opcode SHALL be sampled from IR in DECODE and held internally (3-bit class) for later states; opcode changes after DECODE SHALL NOT alter the flow.
REQ-016 Zero-wait latency: R/I/SW 4 cycles, LW 5, BEQ/BNE/J 3.
REQ-017 Wait counter (width ceil(log2(TIMEOUT+1))) SHALL count cycles in FETCH/MEM_READ/MEM_WRITE with mem_ready=0, clear on any state change or mem_ready=1.
REQ-018 When counter reaches TIMEOUT: bus_error=1 for one cycle, state->FETCH, no pc_write/ir_write/reg_write/mem_write that cycle; counter clears.
REQ-019 mem_ready=1 arriving in the same cycle as the timeout SHALL win: access completes, no bus_error.
REQ-020 Unlisted controls SHALL be 0 in every state.

Reset
REQ-021 On rising clk with reset=0: state=FETCH, wait counter=0, latched opcode class=0.
REQ-022 While reset=0 all outputs SHALL be 0 except state=0; write enables SHALL be 0 even with mem_ready=1.
REQ-023 Reset asserted mid-instruction (any state, including memory wait) SHALL abandon it; first post-reset cycle is FETCH.

Verification
REQ-024 Bench SHALL cover:
  - mem_ready=1, opcode 000000 -> states 0,1,6,7,0; reg_write=1 and alu_op=111 only in state 7.
  - opcode 100011, mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; reg_write with mem_to_reg=1 in state 4.
  - opcode 001101 -> I_WB shows alu_op=101, zero_ext=1, reg_write=1; opcode 000101 -> BRANCH with pc_write_cond_ne=1, alu_op=100.
  - opcode 111111 -> DECODE cycle illegal=1, next state 0, no write enables.
  - mem_ready held 0 in FETCH, TIMEOUT=16 -> bus_error pulse on 16th wait cycle, state stays 0, pc_write never 1; mem_ready=1 on that cycle -> no bus_error.
  - reset=0 in MEM_WRITE with mem_ready=1 -> mem_write=0, next state 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back for a small MIPS-like instruction subset.
// Memory states wait on mem_ready. A wait counter forces a bus_error and a
// return to FETCH when memory stalls for TIMEOUT consecutive cycles.
module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond_eq,
    output logic       pc_write_cond_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       zero_ext,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       illegal,
    output logic       bus_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_RTYPE = 3'b111;
    localparam logic [2:0] ALU_ADDI  = 3'b110;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_ANDI  = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_CMP   = 3'b100;

    // Latched opcode class. Its meaning depends on the state that reads it:
    // MEM_ADDR looks for LW/SW, the I states look for the immediate op, and
    // BRANCH treats anything other than BNE as BEQ.
    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_LW   = 3'd1;
    localparam logic [2:0] CLS_SW   = 3'd2;
    localparam logic [2:0] CLS_ADDI = 3'd3;
    localparam logic [2:0] CLS_ORI  = 3'd4;
    localparam logic [2:0] CLS_ANDI = 3'd5;
    localparam logic [2:0] CLS_LUI  = 3'd6;
    localparam logic [2:0] CLS_BNE  = 3'd7;

    state_t        state_r, next_state_s;
    logic [2:0]    cls_r, next_cls_s;
    logic [CW-1:0] wait_cnt_r;
    logic          waiting_s, timeout_s;

    logic          pc_write_s, cond_eq_s, cond_ne_s, i_or_d_s, mem_read_s;
    logic          mem_write_s, ir_write_s, reg_dst_s, mem_to_reg_s;
    logic          reg_write_s, zero_ext_s, alu_src_a_s, illegal_s, bus_error_s;
    logic [1:0]    alu_src_b_s, pc_source_s;
    logic [2:0]    alu_op_s;

    function automatic logic [2:0] imm_alu_op(input logic [2:0] cls);
        logic [2:0] op;
        case (cls)
            CLS_ADDI: op = ALU_ADDI;
            CLS_ORI:  op = ALU_ORI;
            CLS_ANDI: op = ALU_ANDI;
            CLS_LUI:  op = ALU_LUI;
            default:  op = ALU_ADDI;
        endcase
        return op;
    endfunction

    function automatic logic imm_zero_ext(input logic [2:0] cls);
        return (cls == CLS_ORI) || (cls == CLS_ANDI);
    endfunction

    // Stall detection: memory-facing state with no completion this cycle
    always_comb begin
        waiting_s = 1'b0;
        if ((state_r == S_FETCH) || (state_r == S_MEM_READ) || (state_r == S_MEM_WRITE)) begin
            waiting_s = ~mem_ready;
        end else begin
            waiting_s = 1'b0;
        end
        timeout_s = waiting_s && (wait_cnt_r == CW'(TIMEOUT - 1));
    end

    // Next-state and control decode from the current state
    always_comb begin
        next_state_s = state_r;
        next_cls_s   = cls_r;
        pc_write_s   = 1'b0;
        cond_eq_s    = 1'b0;
        cond_ne_s    = 1'b0;
        i_or_d_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        zero_ext_s   = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_source_s  = 2'b00;
        alu_op_s     = 3'b000;
        illegal_s    = 1'b0;
        bus_error_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALU_ADD;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else if (timeout_s) begin
                    bus_error_s  = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                alu_op_s    = ALU_ADD;
                next_cls_s  = CLS_NONE;
                case (opcode)
                    OP_RTYPE: next_state_s = S_R_EXEC;
                    OP_LW:    begin next_state_s = S_MEM_ADDR; next_cls_s = CLS_LW;   end
                    OP_SW:    begin next_state_s = S_MEM_ADDR; next_cls_s = CLS_SW;   end
                    OP_ADDI:  begin next_state_s = S_I_EXEC;   next_cls_s = CLS_ADDI; end
                    OP_ORI:   begin next_state_s = S_I_EXEC;   next_cls_s = CLS_ORI;  end
                    OP_ANDI:  begin next_state_s = S_I_EXEC;   next_cls_s = CLS_ANDI; end
                    OP_LUI:   begin next_state_s = S_I_EXEC;   next_cls_s = CLS_LUI;  end
                    OP_BEQ:   next_state_s = S_BRANCH;
                    OP_BNE:   begin next_state_s = S_BRANCH;   next_cls_s = CLS_BNE;  end
                    OP_J:     next_state_s = S_JUMP;
                    default: begin
                        illegal_s    = 1'b1;
                        next_state_s = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_op_s    = ALU_ADD;
                if (cls_r == CLS_LW) begin
                    next_state_s = S_MEM_READ;
                end else if (cls_r == CLS_SW) begin
                    next_state_s = S_MEM_WRITE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else if (timeout_s) begin
                    bus_error_s  = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_READ;
                end
            end
            S_MEM_WB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_WRITE: begin
                i_or_d_s = 1'b1;
                if (mem_ready) begin
                    mem_write_s  = 1'b1;
                    next_state_s = S_FETCH;
                end else if (timeout_s) begin
                    bus_error_s  = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    mem_write_s  = 1'b1;
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_R_EXEC: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALU_RTYPE;
                next_state_s = S_R_WB;
            end
            S_R_WB: begin
                reg_dst_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_op_s     = ALU_RTYPE;
                next_state_s = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                alu_op_s     = imm_alu_op(cls_r);
                zero_ext_s   = imm_zero_ext(cls_r);
                next_state_s = S_I_WB;
            end
            S_I_WB: begin
                reg_write_s  = 1'b1;
                alu_op_s     = imm_alu_op(cls_r);
                zero_ext_s   = imm_zero_ext(cls_r);
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALU_CMP;
                pc_source_s  = 2'b01;
                cond_ne_s    = (cls_r == CLS_BNE);
                cond_eq_s    = (cls_r != CLS_BNE);
                next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pc_source_s  = 2'b10;
                pc_write_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            default: next_state_s = S_FETCH;
        endcase
    end

    // State, latched opcode class and stall counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_FETCH;
            cls_r      <= CLS_NONE;
            wait_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            cls_r   <= next_cls_s;
            if (waiting_s && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end else begin
                wait_cnt_r <= '0;
            end
        end
    end

    // Every control is forced low while reset is held, whatever state remains
    assign pc_write         = reset & pc_write_s;
    assign pc_write_cond_eq = reset & cond_eq_s;
    assign pc_write_cond_ne = reset & cond_ne_s;
    assign i_or_d           = reset & i_or_d_s;
    assign mem_read         = reset & mem_read_s;
    assign mem_write        = reset & mem_write_s;
    assign ir_write         = reset & ir_write_s;
    assign reg_dst          = reset & reg_dst_s;
    assign mem_to_reg       = reset & mem_to_reg_s;
    assign reg_write        = reset & reg_write_s;
    assign zero_ext         = reset & zero_ext_s;
    assign alu_src_a        = reset & alu_src_a_s;
    assign alu_src_b        = reset ? alu_src_b_s : 2'b00;
    assign pc_source        = reset ? pc_source_s : 2'b00;
    assign alu_op           = reset ? alu_op_s : 3'b000;
    assign state            = reset ? state_r : 4'd0;
    assign illegal          = reset & illegal_s;
    assign bus_error        = reset & bus_error_s;

endmodule
